// File: rtl/signed_number_object_pkg.sv
// rtl/signed_number_object_pkg.sv - shared types and constants for the signed score display
package signed_number_object_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } fsm_state_e;

  localparam int NUM_SLOTS = 4;

  // [2] = hundreds, [1] = tens, [0] = units
  typedef logic [2:0][3:0] bcd3_t;

  localparam logic [11:0] BCD_MAX = 12'h999;

  // Double-dabble pre-shift correction: +3 on every nibble that is 5 or more.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_number_object_bcd.sv
// rtl/signed_number_object_bcd.sv - sequential signed binary to sign + 3-digit BCD converter
module bin_to_bcd_seq
  import signed_number_object_pkg::*;
#(
  parameter int VALUE_W = 10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic [VALUE_W-1:0] sample,
  output logic               busy,
  output logic               done,
  output logic               sign,
  output bcd3_t              bcd,
  output logic               ovf
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  fsm_state_e         state;
  logic               neg_q;
  logic               nz_q;
  logic               ovf_q;
  logic [VALUE_W-1:0] mag_q;
  logic [11:0]        bcd_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [VALUE_W:0]   sample_ext;
  logic [VALUE_W:0]   mag_full;
  logic [11:0]        bcd_adj;
  logic [12:0]        bcd_shift;

  // One extra bit so that the most negative input negates without wrapping.
  assign sample_ext = {sample[VALUE_W-1], sample};
  assign mag_full   = sample[VALUE_W-1] ? (~sample_ext + {{VALUE_W{1'b0}}, 1'b1}) : sample_ext;

  assign bcd_adj    = dabble_adjust(bcd_q);
  assign bcd_shift  = {bcd_adj, mag_q[VALUE_W-1]};

  assign busy = (state != IDLE);
  assign done = (state == COMMIT);
  assign sign = neg_q & nz_q;
  assign bcd  = ovf_q ? BCD_MAX : bcd_q;
  assign ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      neg_q <= 1'b0;
      nz_q  <= 1'b0;
      ovf_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          neg_q <= sample[VALUE_W-1];
          nz_q  <= |sample;
          mag_q <= mag_full[VALUE_W-1:0];
          bcd_q <= '0;
          ovf_q <= 1'b0;
          cnt_q <= CNT_W'(VALUE_W);
          state <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= bcd_shift[11:0];
          mag_q <= {mag_q[VALUE_W-2:0], 1'b0};
          // A bit leaving the hundreds nibble means the magnitude exceeds 999.
          if (bcd_shift[12]) ovf_q <= 1'b1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/signed_number_object.sv
// rtl/signed_number_object.sv - frame-sampled signed score to minus/digit slot drawer controls
module signed_number_object
  import signed_number_object_pkg::*;
#(
  parameter logic [10:0] TOP_LEFT_X = 11'd20,
  parameter logic [10:0] TOP_LEFT_Y = 11'd20,
  parameter int          DIGIT_W    = 16,
  parameter int          DIGIT_H    = 32,
  parameter int          VALUE_W    = 10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               startOfFrame,
  input  logic [VALUE_W-1:0] value,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic               minusInside,
  output logic               minusOn,
  output logic               digitInside,
  output logic [3:0]         digit,
  output logic               digitOn,
  output logic               overflow,
  output logic               busy
);

  localparam int X0 = int'(TOP_LEFT_X);
  localparam int Y0 = int'(TOP_LEFT_Y);

  logic [VALUE_W-1:0] sample_q;
  logic               conv_done;
  logic               conv_sign;
  bcd3_t              conv_bcd;
  logic               conv_ovf;

  logic               disp_sign;
  bcd3_t              disp_bcd;
  logic               disp_ovf;

  always_ff @(posedge clk) begin
    if (!resetN) sample_q <= '0;
    else if (startOfFrame && !busy) sample_q <= value;
  end

  bin_to_bcd_seq #(.VALUE_W(VALUE_W)) u_conv (
    .clk    (clk),
    .resetN (resetN),
    .start  (startOfFrame),
    .sample (sample_q),
    .busy   (busy),
    .done   (conv_done),
    .sign   (conv_sign),
    .bcd    (conv_bcd),
    .ovf    (conv_ovf)
  );

  // Display registers move only on the converter's commit cycle, never mid-frame.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      disp_sign <= 1'b0;
      disp_bcd  <= '0;
      disp_ovf  <= 1'b0;
    end else if (conv_done) begin
      disp_sign <= conv_sign;
      disp_bcd  <= conv_bcd;
      disp_ovf  <= conv_ovf;
    end
  end

  logic [31:0] px;
  logic [31:0] py;
  logic        in_y;
  logic        hit;
  logic [1:0]  slot;
  logic [10:0] hit_offx;
  logic [3:0]  sel_digit;
  logic        sel_on;

  assign px   = {21'd0, pixelX};
  assign py   = {21'd0, pixelY};
  assign in_y = (py >= 32'(Y0)) && (py < 32'(Y0 + DIGIT_H));

  always_comb begin
    hit      = 1'b0;
    slot     = '0;
    hit_offx = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (in_y && (px >= 32'(X0 + k*DIGIT_W)) && (px < 32'(X0 + (k+1)*DIGIT_W))) begin
        hit      = 1'b1;
        slot     = 2'(k);
        hit_offx = 11'(px - 32'(X0 + k*DIGIT_W));
      end
    end
  end

  always_comb begin
    sel_digit = '0;
    sel_on    = 1'b0;
    case (slot)
      2'd1: begin
        sel_digit = disp_bcd[2];
        sel_on    = (disp_bcd[2] != 4'd0);
      end
      2'd2: begin
        sel_digit = disp_bcd[1];
        sel_on    = (disp_bcd[2] != 4'd0) || (disp_bcd[1] != 4'd0);
      end
      2'd3: begin
        sel_digit = disp_bcd[0];
        sel_on    = 1'b1;
      end
      default: begin
        sel_digit = '0;
        sel_on    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      offsetX     <= '0;
      offsetY     <= '0;
      minusInside <= 1'b0;
      minusOn     <= 1'b0;
      digitInside <= 1'b0;
      digit       <= '0;
      digitOn     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      offsetX     <= hit ? hit_offx : 11'd0;
      offsetY     <= hit ? (pixelY - TOP_LEFT_Y) : 11'd0;
      minusInside <= hit && (slot == 2'd0);
      minusOn     <= disp_sign;
      digitInside <= hit && (slot != 2'd0);
      digit       <= (hit && (slot != 2'd0)) ? sel_digit : 4'd0;
      digitOn     <= hit && (slot != 2'd0) && sel_on;
      overflow    <= disp_ovf;
    end
  end

endmodule

// File: doc/signed_number_object.md
Name: signed_number_object

Overview:
Upstream driver for the minus/digit bitmap drawers. Takes the VGA pixel coordinate and a signed score value, and produces the per-slot rectangle hit, the offsets, the digit code and the on/off enables those drawers consume. The value is sampled once per frame and converted to sign plus BCD by a sequential double-dabble FSM, so the displayed number never changes mid-frame. Sits between the VGA controller/game logic and the minus/number bitmap modules.

Parameters:
TOP_LEFT_X, 11'd20, screen X of the left edge of slot 0.
TOP_LEFT_Y, 11'd20, screen Y of the top edge of all slots.
DIGIT_W, 16, slot width in pixels; must match the bitmap width.
DIGIT_H, 32, slot height in pixels; must match the bitmap height.
VALUE_W, 10, width of the signed input value; legal range 4..16.

Ports:
clk  in  1  system clock.
resetN  in  1  synchronous active-low reset.
pixelX  in  11  current pixel column from the VGA controller.
pixelY  in  11  current pixel row from the VGA controller.
startOfFrame  in  1  one-cycle pulse at the start of each frame.
value  in  VALUE_W  signed two's-complement value to display.
offsetX  out  11  pixelX minus the left edge of the hit slot; 0 when no slot is hit.
offsetY  out  11  pixelY minus TOP_LEFT_Y; 0 when no slot is hit.
minusInside  out  1  pixel lies in slot 0 (the minus slot).
minusOn  out  1  displayed value is negative.
digitInside  out  1  pixel lies in slot 1, 2 or 3.
digit  out  4  BCD digit for the hit slot: slot 1 = hundreds, slot 2 = tens, slot 3 = units.
digitOn  out  1  the hit digit is not a blanked leading zero.
overflow  out  1  displayed magnitude was saturated to 999.
busy  out  1  conversion in progress.

Behaviour:
- Reset, synchronous on the clk edge while resetN=0:
  - All outputs are 0.
  - Display registers are sign=0, BCD=000, overflow=0. Reset therefore shows "0".
  - FSM goes to IDLE. A reset asserted mid-conversion aborts it; display registers are cleared.
- FSM states IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: startOfFrame=1 -> LOAD. In the same edge, capture value into the sample register.
  - LOAD:
    - neg = sample[MSB].
    - mag = neg ? (~sample + 1) : sample, computed VALUE_W+1 bits wide so that -2^(VALUE_W-1) is correct.
    - Clear the 12-bit BCD shift register, set the iteration counter to VALUE_W. Go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is >=5, then shift {bcd, mag} left by 1. Decrement the counter. Leave SHIFT when the counter reaches 0.
    - A hundreds carry-out, or a magnitude >999, sets a sticky ovf flag. Use a 13th BCD bit for detection.
  - COMMIT:
    - Display registers <= sign, BCD digits and overflow. If ovf, the BCD digits are 999.
    - sign = neg AND (mag != 0).
    - Return to IDLE.
- Conversion latency is VALUE_W+3 cycles from the startOfFrame edge to the display update; 13 cycles at the default. This is well inside vertical blanking.
- busy=1 in LOAD, SHIFT and COMMIT.
- A startOfFrame pulse while busy is ignored; the current conversion completes.
- Display registers change only in COMMIT.
- Slot geometry:
  - slot k spans X in [TOP_LEFT_X + k*DIGIT_W, TOP_LEFT_X + (k+1)*DIGIT_W - 1] and Y in [TOP_LEFT_Y, TOP_LEFT_Y + DIGIT_H - 1], for k = 0..3.
  - Bounds are inclusive on both ends; comparisons are unsigned 11-bit.
- Pixel path: offsetX, offsetY, minusInside, minusOn, digitInside, digit, digitOn and overflow are registered, with exactly 1 cycle latency from pixelX/pixelY. Outside all slots, all hit outputs and offsets are 0 and digit=0.
- minusOn reflects the displayed sign, independent of the pixel position.
- Leading-zero blanking:
  - hundreds is on iff hundreds != 0.
  - tens is on iff hundreds != 0 or tens != 0.
  - units is always on.
- overflow mirrors the displayed overflow register.

Decomposition:
- A shared package holds:
  - the FSM state enum (IDLE/LOAD/SHIFT/COMMIT);
  - the constant NUM_SLOTS=4;
  - the typedef bcd3_t, a packed array of 3 by 4-bit digits;
  - the constant BCD_MAX = 12'h999.
- One sub-module, bin_to_bcd_seq, is natural. It holds the LOAD/SHIFT/COMMIT datapath with a start/busy/done handshake.
- The top level holds the frame sampling, display registers and slot decode.

Test Plan:
- Reset held for 3 cycles, then released with no startOfFrame. Pixel (TOP_LEFT_X+48, TOP_LEFT_Y+5) -> one cycle later digitInside=1, digit=0, digitOn=1, minusOn=0, offsetX=0, offsetY=5.
- value=10'sd137, startOfFrame pulse, wait 13 cycles. Sweep slots 1..3 -> digit 1/3/7 with digitOn=1/1/1; minusInside=1 at slot 0 with minusOn=0.
- value=-10'sd512 -> minusOn=1, digits 5/1/2, overflow=0. value=-10'sd5 -> minusOn=1, digits 0/0/5 with digitOn=0/0/1.
- Re-instantiate with VALUE_W=12 and value=12'sd1500 -> overflow=1, digits 9/9/9, minusOn=0.
- startOfFrame pulsed again 4 cycles after the first, and value changed from 37 to 88 before the second pulse -> second pulse ignored; display shows 037 (hundreds blanked), and busy drops after 13 cycles.
- Reset asserted during SHIFT after an earlier display of 250 -> the next cycle shows digits 0/0/0, busy=0. Boundary pixels TOP_LEFT_X-1 and TOP_LEFT_X+64 -> all hit outputs 0. The pixel at X=TOP_LEFT_X+15, Y=TOP_LEFT_Y+31 gives minusInside=1, offsetX=15, offsetY=31.
